// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around a dual-port BRAM with a 2-cycle registered read.
// A 4-entry output buffer absorbs in-flight reads, so a stalled consumer never drops data.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] data_count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_din,
  output logic                  ram_rd_en,
  output logic                  ram_rd_regcke,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_dout
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] MEM_SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [3:0]    OB_LIMIT = 4'(OBUF_DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr, ram_count, ram_count_next;
  logic                  st1_v, st2_v;
  logic [DATA_WIDTH-1:0] ob_mem [OBUF_DEPTH];
  logic [1:0]            ob_wr, ob_rd;
  logic [2:0]            ob_count, ob_count_next;
  logic [3:0]            credit_used;
  logic                  push, pop;
  logic [CW-1:0]         data_count_next;
  logic                  unused_ptr_msbs;

  // Pointer MSBs only track lap parity; full/empty come from ram_count.
  assign unused_ptr_msbs = &{1'b0, wr_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH]};

  // Write side
  assign ram_wr_en   = s_valid & s_ready;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_din  = s_data;

  // Read issue: credit covers buffered plus in-flight words; this cycle's pop is ignored.
  assign credit_used   = {1'b0, ob_count} + {3'b0, st1_v} + {3'b0, st2_v};
  assign ram_rd_en     = (ram_count != '0) && (credit_used < OB_LIMIT);
  assign ram_rd_addr   = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_regcke = st1_v;

  // Output buffer
  assign push    = st2_v;
  assign m_valid = (ob_count != 3'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? ob_mem[ob_rd] : '0;

  always_comb begin
    ram_count_next = ram_count;
    ob_count_next  = ob_count;
    case ({ram_wr_en, ram_rd_en})
      2'b10:   ram_count_next = ram_count + PW'(1);
      2'b01:   ram_count_next = ram_count - PW'(1);
      default: ;
    endcase
    case ({push, pop})
      2'b10:   ob_count_next = ob_count + 3'd1;
      2'b01:   ob_count_next = ob_count - 3'd1;
      default: ;
    endcase
    data_count_next = CW'(ram_count_next) + CW'(ram_rd_en) + CW'(st1_v) + CW'(ob_count_next);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_count  <= '0;
      s_ready    <= 1'b0;
      st1_v      <= 1'b0;
      st2_v      <= 1'b0;
      ob_wr      <= '0;
      ob_rd      <= '0;
      ob_count   <= '0;
      data_count <= '0;
    end else begin
      if (ram_wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (ram_rd_en) rd_ptr <= rd_ptr + PW'(1);
      ram_count  <= ram_count_next;
      s_ready    <= (ram_count_next < MEM_SIZE);
      // Read pipeline: array latch stage, then output register stage
      st1_v      <= ram_rd_en;
      st2_v      <= st1_v;
      if (push) ob_wr <= ob_wr + 2'd1;
      if (pop)  ob_rd <= ob_rd + 2'd1;
      ob_count   <= ob_count_next;
      data_count <= data_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ob_mem[ob_wr] <= ram_rd_dout;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 2-cycle-latency BRAM model.
module tb_ram_fifo_ctrl;
  localparam int AW = 10;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW+1:0] data_count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_din;
  logic          ram_rd_en;
  logic          ram_rd_regcke;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_dout;

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OBUF_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .data_count(data_count),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_din(ram_wr_din),
    .ram_rd_en(ram_rd_en), .ram_rd_regcke(ram_rd_regcke),
    .ram_rd_addr(ram_rd_addr), .ram_rd_dout(ram_rd_dout)
  );

  always #5 clk = ~clk;

  // BRAM model: array latch on port1_en, output register on port1_regcke
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_latch;
  logic [DW-1:0] rd_reg;
  always @(posedge clk) begin
    if (ram_wr_en)     mem[ram_wr_addr] <= ram_wr_din;
    if (ram_rd_en)     rd_latch <= mem[ram_rd_addr];
    if (ram_rd_regcke) rd_reg <= rd_latch;
  end
  assign ram_rd_dout = rd_reg;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          e_sr;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic          e_ren;
    logic          e_rck;
    logic          e_mv;
    logic [DW-1:0] e_md;
    logic [AW+1:0] e_dc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, exp_i, sent, rcv, first, bubbles;
    logic seen;
    logic [DW-1:0] q [$];
    logic [DW-1:0] expw;

    //            sv  sd        mr   sr  wen waddr ren rck mv  md        dc
    tbl[0]  = '{1'b1, 18'h155, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 18'h0,   12'd0};
    tbl[1]  = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, 18'h0,   12'd1};
    tbl[2]  = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 18'h0,   12'd1};
    tbl[3]  = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 18'h0,   12'd1};
    tbl[4]  = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b1, 18'h155, 12'd1};
    tbl[5]  = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 18'h0,   12'd0};
    tbl[6]  = '{1'b1, 18'h3AB, 1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 18'h0,   12'd0};
    tbl[7]  = '{1'b0, 18'h0,   1'b0, 1'b1, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, 18'h0,   12'd1};
    tbl[8]  = '{1'b0, 18'h0,   1'b0, 1'b1, 1'b0, 10'd2, 1'b0, 1'b1, 1'b0, 18'h0,   12'd1};
    tbl[9]  = '{1'b0, 18'h0,   1'b0, 1'b1, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 18'h0,   12'd1};
    tbl[10] = '{1'b0, 18'h0,   1'b0, 1'b1, 1'b0, 10'd2, 1'b0, 1'b0, 1'b1, 18'h3AB, 12'd1};
    tbl[11] = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd2, 1'b0, 1'b0, 1'b1, 18'h3AB, 12'd1};
    tbl[12] = '{1'b0, 18'h0,   1'b1, 1'b1, 1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 18'h0,   12'd0};

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Reset held for 5 cycles
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_data_count", data_count, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_regcke", ram_rd_regcke, 0);
    chk("rst_m_data", m_data, 0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_s_ready_before_edge", s_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("release_s_ready_after_edge", s_ready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_s_ready", s_ready, 0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Single-word vectors
    for (int i = 0; i < 13; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_wr_en", i), ram_wr_en, tbl[i].e_wen);
      chk($sformatf("vec%0d_wr_addr", i), ram_wr_addr, tbl[i].e_waddr);
      chk($sformatf("vec%0d_rd_en", i), ram_rd_en, tbl[i].e_ren);
      chk($sformatf("vec%0d_regcke", i), ram_rd_regcke, tbl[i].e_rck);
      chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
      chk($sformatf("vec%0d_data_count", i), data_count, tbl[i].e_dc);
      next_cycle();
    end

    // Fill with consumer stalled
    s_valid = 1'b1;
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 1100; c++) begin
      s_data = DW'(acc);
      @(negedge clk);
      if (s_ready) acc++;
      next_cycle();
    end
    s_valid = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("fill_accepted", acc, 1028);
    chk("fill_s_ready", s_ready, 0);
    chk("fill_data_count", data_count, 1028);
    chk("fill_m_valid", m_valid, 1);
    next_cycle();
    m_ready = 1'b1;
    exp_i = 0;
    seen = 1'b0;
    for (int c = 0; c < 1300 && exp_i < 1028; c++) begin
      @(negedge clk);
      if (s_ready) seen = 1'b1;
      if (m_valid) begin
        chk("fill_order", m_data, exp_i);
        exp_i++;
      end
      next_cycle();
    end
    chk("fill_drained", exp_i, 1028);
    chk("fill_s_ready_rise", seen, 1);
    @(negedge clk);
    chk("fill_empty_count", data_count, 0);
    next_cycle();

    // Streaming at full rate
    s_valid = 1'b1;
    m_ready = 1'b1;
    sent = 0; rcv = 0; first = -1; bubbles = 0;
    for (int c = 0; c < 3200 && rcv < 3000; c++) begin
      s_valid = (sent < 3000);
      s_data  = DW'(20000 + sent);
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      if (m_valid) begin
        chk("stream_order", m_data, 20000 + rcv);
        if (first < 0) first = c;
        rcv++;
      end else if (first >= 0) begin
        bubbles++;
      end
      next_cycle();
    end
    s_valid = 1'b0;
    chk("stream_latency", first, 4);
    chk("stream_count", rcv, 3000);
    chk("stream_bubbles", bubbles, 0);

    // Random backpressure with scoreboard
    sent = 0; rcv = 0;
    repeat (6) next_cycle();
    for (int c = 0; c < 60000 && rcv < 10000; c++) begin
      s_valid = (sent < 10000) && ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 1) == 1);
      s_data  = DW'($urandom);
      @(negedge clk);
      chk("bp_data_count", data_count, q.size());
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
      end
      if (m_valid && m_ready) begin
        chk("bp_pop_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          expw = q.pop_front();
          chk("bp_order", m_data, expw);
        end
        rcv++;
      end
      next_cycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("bp_sent", sent, 10000);
    chk("bp_received", rcv, 10000);

    // Reset with words stored and reads in flight
    repeat (3) next_cycle();
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = DW'(18'h100 + i);
      next_cycle();
    end
    s_valid = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("mid_stored_count", data_count, 10);
    next_cycle();
    m_ready = 1'b1;
    repeat (2) next_cycle();
    m_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("mid_inflight_regcke", ram_rd_regcke, 1);
    chk("mid_inflight_count", data_count, 8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_data_count", data_count, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_rd_en", ram_rd_en, 0);
    chk("mid_rst_regcke", ram_rd_regcke, 0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    s_valid = 1'b1;
    s_data  = 18'h0AA;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    next_cycle();
    s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) begin
        chk("post_rst_first_word", m_data, 18'h0AA);
        seen = 1'b1;
      end
      next_cycle();
    end
    chk("post_rst_word_seen", seen, 1);
    @(negedge clk);
    chk("post_rst_empty", data_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
